pcpi_mul_arbiter: RTL and testbench
===================================

Name: pcpi_mul_arbiter

Overview:
- Shares one PCPI multiply coprocessor (MUL/MULH/MULHSU/MULHU, downstream) between two PCPI requester ports (two cores or harts).
- Decodes multiply instructions, arbitrates between the two ports, and sequences one transaction at a time to the coprocessor.
- Keeps each losing requester stalled with pcpi_wait.
- Aborts and releases the coprocessor if it never responds.

Parameters:
- ROUND_ROBIN, 1, 1 = alternate grant on simultaneous requests; 0 = port 0 has fixed priority.
- TIMEOUT, 16, BUSY cycles allowed with neither m_pcpi_wait nor m_pcpi_ready before abort; legal range 2..255.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- pN_pcpi_valid  in  1  request from port N (N = 0, 1)
- pN_pcpi_insn  in  32  instruction word
- pN_pcpi_rs1  in  32  operand 1
- pN_pcpi_rs2  in  32  operand 2
- pN_pcpi_wr  out  1  result-valid pulse
- pN_pcpi_rd  out  32  result
- pN_pcpi_wait  out  1  request accepted or queued, hold
- pN_pcpi_ready  out  1  completion pulse
- m_pcpi_valid  out  1  request to the shared coprocessor
- m_pcpi_insn, m_pcpi_rs1, m_pcpi_rs2  out  32 each  captured operands
- m_pcpi_wr  in  1  coprocessor result valid
- m_pcpi_rd  in  32  coprocessor result
- m_pcpi_wait  in  1  coprocessor busy
- m_pcpi_ready  in  1  coprocessor done
- grant_owner  out  1  port that owns the current transaction
- timeout_err  out  1  one-cycle pulse on abort

Behaviour:
- Clock and reset: single clock clk; resetn is asynchronous, active low.
- Reset values: all outputs 0, including rd buses and m_* operands. State IDLE, last_grant=1 (so port 0 wins first), blocked=00, counter=0.
- Reset mid-transaction returns to IDLE immediately and drops m_pcpi_valid. The coprocessor is assumed to share resetn.
- Match: match[N] = valid && insn[6:0]==7'b0110011 && insn[31:25]==7'b0000001 && insn[14]==0.
- Non-matching requests are ignored entirely: no wait, no ready.
- req[N] = match[N] && !blocked[N].
- blocked[N] is set on an abort for port N and cleared when pN_pcpi_valid is seen low.
- All outputs are registered.
- IDLE:
  - If any req, pick the winner: a single requester wins; on a tie, ROUND_ROBIN=1 picks !last_grant, ROUND_ROBIN=0 picks port 0.
  - Capture the winner's insn/rs1/rs2 into the m_* registers, set grant_owner and last_grant, clear the counter, go to BUSY.
  - m_pcpi_valid goes to 1 on the next cycle.
- BUSY:
  - m_pcpi_valid=1 and m_* operands are held stable.
  - The counter increments each cycle with m_pcpi_wait=0 and m_pcpi_ready=0. It clears whenever m_pcpi_wait=1.
  - On m_pcpi_ready: register m_pcpi_rd into the owner's rd, pulse the owner's ready (and wr if m_pcpi_wr), drop m_pcpi_valid, go to RESP.
  - If the counter reaches TIMEOUT-1 with no wait or ready: drop m_pcpi_valid, pulse timeout_err, set blocked[owner], go to RESP without a ready pulse.
  - m_pcpi_ready has priority over timeout in the same cycle.
- RESP: one-cycle gap with m_pcpi_valid=0 so the coprocessor's decode clears. Then go to IDLE.
- RESP-to-IDLE timing: the owner drops valid the cycle after ready, so no stale regrant occurs. If the owner's valid is still high in IDLE, that is treated as a new request.
- pN_pcpi_wait (registered):
  - 1 while req[N] && !(state in {BUSY, RESP} with owner N having completed).
  - Goes low in the same cycle the ready pulse is driven.
  - A blocked port sees wait=0, so its core's own PCPI timeout fires (illegal instruction).
- Non-owner rd holds its last value; wr and ready stay 0.
- Latency: a granted request reaches m_pcpi_valid 1 cycle after the grant decision. The result reaches the owner 1 cycle after m_pcpi_ready.
- A simultaneous new request from the non-owner during BUSY waits; it is granted in the IDLE after RESP.
- Back-to-back requests from the same port are allowed. Round robin still alternates if both are pending.

Decomposition:
- Shared package pcpi_pkg:
  - OPCODE_OP=7'b0110011, FUNCT7_MULDIV=7'b0000001.
  - State enum {IDLE, BUSY, RESP}.
  - PCPI request/response struct typedefs (valid, insn, rs1, rs2 / wr, rd, wait, ready).
- One sub-module: pcpi_rr_arb2, a 2-way round-robin/fixed-priority picker (req[1:0], last_grant, mode → grant, any). Decode, FSM, timeout and muxing stay in the top.

Test Plan:
- Port 0 only, MUL rs1=7, rs2=6, with pcpi_mul attached → p0_pcpi_ready and p0_pcpi_wr pulse once, p0_pcpi_rd=42; p1 outputs stay 0; p0_pcpi_wait low on the ready cycle.
- Both ports request in the same cycle (p0 MULHU 0xFFFFFFFF*0xFFFFFFFF, p1 MUL 3*-5) with ROUND_ROBIN=1:
  - p0 served first, rd=0xFFFFFFFE; p1 rd=0xFFFFFFF1.
  - p1_pcpi_wait stays 1 throughout.
  - Repeat: p1 is served first.
- ROUND_ROBIN=0, port 0 re-requests continuously while p1 waits → p0 is always granted; p1_pcpi_wait held at 1.
- Stub coprocessor never asserts wait or ready, TIMEOUT=16:
  - timeout_err pulses exactly 16 cycles after m_pcpi_valid rises; p0_pcpi_wait drops; no ready pulse.
  - p0 is not regranted until its valid drops.
- Non-matching instruction on p1 (ADD, funct7=0) → no m_pcpi_valid, p1 wait/ready stay 0.
- resetn asserted low mid-BUSY → all outputs 0 asynchronously. After release, a MUL 2*3 on p1 completes with rd=6.

Source files
------------

// File: rtl/pcpi_pkg.sv
// rtl/pcpi_pkg.sv - shared PCPI types, decode constants and arbiter state encoding
package pcpi_pkg;

   localparam logic [6:0] OPCODE_OP     = 7'b0110011;
   localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } arb_state_t;

   typedef struct packed {
      logic        valid;
      logic [31:0] insn;
      logic [31:0] rs1;
      logic [31:0] rs2;
   } pcpi_req_t;

   typedef struct packed {
      logic        wr;
      logic [31:0] rd;
      logic        pwait;
      logic        ready;
   } pcpi_rsp_t;

   // MUL/MULH/MULHSU/MULHU only; funct3[2] set means DIV/REM, which is not ours.
   function automatic logic is_mul(input logic valid, input logic [31:0] insn);
      return valid && (insn[6:0] == OPCODE_OP) && (insn[31:25] == FUNCT7_MULDIV) && !insn[14];
   endfunction

endpackage

// File: rtl/pcpi_rr_arb2.sv
// rtl/pcpi_rr_arb2.sv - two-way round-robin / fixed-priority picker
module pcpi_rr_arb2 (
   input  logic [1:0] req,
   input  logic       last_grant,
   input  logic       mode,
   output logic       grant,
   output logic       any
);

   always_comb begin
      any = |req;
      case (req)
         2'b10:   grant = 1'b1;
         2'b11:   grant = mode ? ~last_grant : 1'b0;
         default: grant = 1'b0;
      endcase
   end

endmodule

// File: rtl/pcpi_mul_arbiter.sv
// rtl/pcpi_mul_arbiter.sv - shares one PCPI multiply coprocessor between two requester ports
module pcpi_mul_arbiter
   import pcpi_pkg::*;
#(
   parameter bit ROUND_ROBIN = 1'b1,
   parameter int TIMEOUT     = 16
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        p0_pcpi_valid,
   input  logic [31:0] p0_pcpi_insn,
   input  logic [31:0] p0_pcpi_rs1,
   input  logic [31:0] p0_pcpi_rs2,
   output logic        p0_pcpi_wr,
   output logic [31:0] p0_pcpi_rd,
   output logic        p0_pcpi_wait,
   output logic        p0_pcpi_ready,
   input  logic        p1_pcpi_valid,
   input  logic [31:0] p1_pcpi_insn,
   input  logic [31:0] p1_pcpi_rs1,
   input  logic [31:0] p1_pcpi_rs2,
   output logic        p1_pcpi_wr,
   output logic [31:0] p1_pcpi_rd,
   output logic        p1_pcpi_wait,
   output logic        p1_pcpi_ready,
   output logic        m_pcpi_valid,
   output logic [31:0] m_pcpi_insn,
   output logic [31:0] m_pcpi_rs1,
   output logic [31:0] m_pcpi_rs2,
   input  logic        m_pcpi_wr,
   input  logic [31:0] m_pcpi_rd,
   input  logic        m_pcpi_wait,
   input  logic        m_pcpi_ready,
   output logic        grant_owner,
   output logic        timeout_err
);

   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   pcpi_req_t [1:0] req_in;
   pcpi_rsp_t [1:0] rsp_q, rsp_d;
   arb_state_t      state_q, state_d;
   logic            owner_q, owner_d, last_q, last_d;
   logic [1:0]      blocked_q, blocked_d, match, req;
   logic [7:0]      cnt_q, cnt_d;
   logic            m_valid_q, m_valid_d, timeout_q, timeout_d;
   logic [31:0]     m_insn_q, m_insn_d, m_rs1_q, m_rs1_d, m_rs2_q, m_rs2_d;
   logic            pick, pick_any, release_now;

   assign req_in[0] = '{valid: p0_pcpi_valid, insn: p0_pcpi_insn, rs1: p0_pcpi_rs1, rs2: p0_pcpi_rs2};
   assign req_in[1] = '{valid: p1_pcpi_valid, insn: p1_pcpi_insn, rs1: p1_pcpi_rs1, rs2: p1_pcpi_rs2};

   always_comb begin
      for (int n = 0; n < 2; n++) begin
         match[n] = is_mul(req_in[n].valid, req_in[n].insn);
      end
      req = match & ~blocked_q;
   end

   pcpi_rr_arb2 u_arb (
      .req        (req),
      .last_grant (last_q),
      .mode       (ROUND_ROBIN),
      .grant      (pick),
      .any        (pick_any)
   );

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      last_d      = last_q;
      cnt_d       = cnt_q;
      m_valid_d   = 1'b0;
      m_insn_d    = m_insn_q;
      m_rs1_d     = m_rs1_q;
      m_rs2_d     = m_rs2_q;
      timeout_d   = 1'b0;
      release_now = 1'b0;
      // A port's abort lock lasts until its core withdraws the request.
      blocked_d   = blocked_q & {p1_pcpi_valid, p0_pcpi_valid};
      for (int n = 0; n < 2; n++) begin
         rsp_d[n].rd    = rsp_q[n].rd;
         rsp_d[n].wr    = 1'b0;
         rsp_d[n].ready = 1'b0;
         rsp_d[n].pwait = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (pick_any) begin
               owner_d   = pick;
               last_d    = pick;
               cnt_d     = 8'd0;
               m_valid_d = 1'b1;
               m_insn_d  = req_in[pick].insn;
               m_rs1_d   = req_in[pick].rs1;
               m_rs2_d   = req_in[pick].rs2;
               state_d   = BUSY;
            end
         end
         BUSY: begin
            m_valid_d = 1'b1;
            if (m_pcpi_ready) begin
               release_now           = 1'b1;
               rsp_d[owner_q].rd     = m_pcpi_rd;
               rsp_d[owner_q].wr     = m_pcpi_wr;
               rsp_d[owner_q].ready  = 1'b1;
               m_valid_d             = 1'b0;
               state_d               = RESP;
            end else if (m_pcpi_wait) begin
               cnt_d = 8'd0;
            end else if (cnt_q == TO_LAST) begin
               release_now         = 1'b1;
               blocked_d[owner_q]  = 1'b1;
               timeout_d           = 1'b1;
               m_valid_d           = 1'b0;
               state_d             = RESP;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // The owner stops waiting on the cycle its result (or abort) is presented.
      for (int n = 0; n < 2; n++) begin
         rsp_d[n].pwait = req[n] && !((owner_q == 1'(n)) && (release_now || state_q == RESP));
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= IDLE;
         owner_q   <= 1'b0;
         last_q    <= 1'b1;
         blocked_q <= 2'b00;
         cnt_q     <= 8'd0;
         m_valid_q <= 1'b0;
         m_insn_q  <= 32'd0;
         m_rs1_q   <= 32'd0;
         m_rs2_q   <= 32'd0;
         timeout_q <= 1'b0;
         rsp_q     <= '0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         last_q    <= last_d;
         blocked_q <= blocked_d;
         cnt_q     <= cnt_d;
         m_valid_q <= m_valid_d;
         m_insn_q  <= m_insn_d;
         m_rs1_q   <= m_rs1_d;
         m_rs2_q   <= m_rs2_d;
         timeout_q <= timeout_d;
         rsp_q     <= rsp_d;
      end
   end

   assign p0_pcpi_wr    = rsp_q[0].wr;
   assign p0_pcpi_rd    = rsp_q[0].rd;
   assign p0_pcpi_wait  = rsp_q[0].pwait;
   assign p0_pcpi_ready = rsp_q[0].ready;
   assign p1_pcpi_wr    = rsp_q[1].wr;
   assign p1_pcpi_rd    = rsp_q[1].rd;
   assign p1_pcpi_wait  = rsp_q[1].pwait;
   assign p1_pcpi_ready = rsp_q[1].ready;
   assign m_pcpi_valid  = m_valid_q;
   assign m_pcpi_insn   = m_insn_q;
   assign m_pcpi_rs1    = m_rs1_q;
   assign m_pcpi_rs2    = m_rs2_q;
   assign grant_owner   = owner_q;
   assign timeout_err   = timeout_q;

endmodule

// File: tb/tb_pcpi_mul_arbiter.sv
// tb/tb_pcpi_mul_arbiter.sv - self-checking bench: round-robin and fixed-priority arbiters with a multiplier model
module tb_pcpi_mul_arbiter;

   typedef struct {
      logic [31:0] insn;
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic [31:0] exp_rd;
   } vec_t;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   logic        p0_valid, p1_valid;
   logic [31:0] p0_insn, p0_rs1, p0_rs2, p1_insn, p1_rs1, p1_rs2;
   logic [1:0]  p0_wr, p0_wait, p0_ready, p1_wr, p1_wait, p1_ready;
   logic [1:0]  m_valid, grant_owner, timeout_err, any_out;
   logic [1:0][31:0] p0_rd, p1_rd, m_insn, m_rs1, m_rs2;
   bit          stub;

   vec_t        vt[7];
   int          pq0[$], pq1[$];
   logic [31:0] sb0[$], sb1[$];
   int          tests = 0;
   int          fails = 0;

   function automatic logic [31:0] mul_ref(input logic [31:0] insn, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] x, y, p;
      x = (insn[13:12] != 2'b11) ? {{32{a[31]}}, a} : {32'd0, a};
      y = (insn[13:12] == 2'b00 || insn[13:12] == 2'b01) ? {{32{b[31]}}, b} : {32'd0, b};
      p = x * y;
      return (insn[13:12] == 2'b00) ? p[31:0] : p[63:32];
   endfunction

   // Instance 0 is round robin, instance 1 fixed priority; both see the same requests.
   for (genvar g = 0; g < 2; g++) begin : g_inst
      logic        cp_ready, cp_wr, cp_wait;
      logic [31:0] cp_rd;
      logic [2:0]  cp_cnt;

      pcpi_mul_arbiter #(.ROUND_ROBIN(g == 0), .TIMEOUT(16)) u_dut (
         .clk           (clk),
         .resetn        (resetn),
         .p0_pcpi_valid (p0_valid),
         .p0_pcpi_insn  (p0_insn),
         .p0_pcpi_rs1   (p0_rs1),
         .p0_pcpi_rs2   (p0_rs2),
         .p0_pcpi_wr    (p0_wr[g]),
         .p0_pcpi_rd    (p0_rd[g]),
         .p0_pcpi_wait  (p0_wait[g]),
         .p0_pcpi_ready (p0_ready[g]),
         .p1_pcpi_valid (p1_valid),
         .p1_pcpi_insn  (p1_insn),
         .p1_pcpi_rs1   (p1_rs1),
         .p1_pcpi_rs2   (p1_rs2),
         .p1_pcpi_wr    (p1_wr[g]),
         .p1_pcpi_rd    (p1_rd[g]),
         .p1_pcpi_wait  (p1_wait[g]),
         .p1_pcpi_ready (p1_ready[g]),
         .m_pcpi_valid  (m_valid[g]),
         .m_pcpi_insn   (m_insn[g]),
         .m_pcpi_rs1    (m_rs1[g]),
         .m_pcpi_rs2    (m_rs2[g]),
         .m_pcpi_wr     (cp_wr),
         .m_pcpi_rd     (cp_rd),
         .m_pcpi_wait   (cp_wait),
         .m_pcpi_ready  (cp_ready),
         .grant_owner   (grant_owner[g]),
         .timeout_err   (timeout_err[g])
      );

      always_ff @(posedge clk or negedge resetn) begin
         if (!resetn) begin
            cp_ready <= 1'b0;
            cp_wr    <= 1'b0;
            cp_wait  <= 1'b0;
            cp_rd    <= 32'd0;
            cp_cnt   <= 3'd0;
         end else begin
            cp_ready <= 1'b0;
            cp_wr    <= 1'b0;
            if (m_valid[g] && !stub && !cp_ready) begin
               if (cp_cnt == 3'd3) begin
                  cp_ready <= 1'b1;
                  cp_wr    <= 1'b1;
                  cp_wait  <= 1'b0;
                  cp_cnt   <= 3'd0;
                  cp_rd    <= mul_ref(m_insn[g], m_rs1[g], m_rs2[g]);
               end else begin
                  cp_wait <= 1'b1;
                  cp_cnt  <= cp_cnt + 3'd1;
               end
            end else if (!m_valid[g]) begin
               cp_wait <= 1'b0;
               cp_cnt  <= 3'd0;
            end
         end
      end

      assign any_out[g] = |{p0_wr[g], p0_rd[g], p0_wait[g], p0_ready[g], p1_wr[g], p1_rd[g], p1_wait[g],
                            p1_ready[g], m_valid[g], m_insn[g], m_rs1[g], m_rs2[g], grant_owner[g], timeout_err[g]};
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %b, expected %b", name, act, exp);
      end
   endtask

   function automatic logic [31:0] mk_insn(input logic [6:0] f7, input logic [2:0] f3);
      return {f7, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
   endfunction

   function automatic logic [34:0] port_out(input int g, input int n);
      if (n == 0) return {p0_ready[g], p0_wr[g], p0_wait[g], p0_rd[g]};
      return {p1_ready[g], p1_wr[g], p1_wait[g], p1_rd[g]};
   endfunction

   task automatic set_port(input int n, input logic v, input int idx);
      if (n == 0) begin
         p0_valid = v; p0_insn = vt[idx].insn; p0_rs1 = vt[idx].rs1; p0_rs2 = vt[idx].rs2;
      end else begin
         p1_valid = v; p1_insn = vt[idx].insn; p1_rs1 = vt[idx].rs1; p1_rs2 = vt[idx].rs2;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      resetn = 1'b0;
      stub = 1'b0;
      set_port(0, 1'b0, 0);
      set_port(1, 1'b0, 0);
      repeat (2) @(negedge clk);
      resetn = 1'b1;
   endtask

   // Acts as both cores: issues queued requests, drops valid after ready, scores results.
   task automatic run_ports(input int g, input int budget, output int order);
      bit          busy[2], used[2], wait_bad[2], spur[2], quiet_bad[2];
      bit          done;
      logic [34:0] o;
      logic [31:0] exp_rd;
      int          idx;
      order = 0;
      done = 1'b0;
      used[0] = (pq0.size() > 0);
      used[1] = (pq1.size() > 0);
      for (int n = 0; n < 2; n++) begin
         busy[n] = 1'b0; wait_bad[n] = 1'b0; spur[n] = 1'b0; quiet_bad[n] = 1'b0;
      end
      for (int c = 0; c < budget && !done; c++) begin
         @(negedge clk);
         for (int n = 0; n < 2; n++) begin
            o = port_out(g, n);
            if (busy[n] && o[34]) begin
               if (n == 0) exp_rd = sb0.pop_front();
               else        exp_rd = sb1.pop_front();
               check($sformatf("p%0d_rd", n), o[31:0], exp_rd);
               check1($sformatf("p%0d_wr_on_ready", n), o[33], 1'b1);
               check1($sformatf("p%0d_wait_on_ready", n), o[32], 1'b0);
               order = order * 4 + n + 1;
               set_port(n, 1'b0, 0);
               busy[n] = 1'b0;
            end else if (busy[n]) begin
               if (!o[32]) wait_bad[n] = 1'b1;
            end else begin
               if (o[34] || o[33]) spur[n] = 1'b1;
               if (!used[n] && o != '0) quiet_bad[n] = 1'b1;
               if (n == 0 && pq0.size() > 0) begin
                  idx = pq0.pop_front();
                  set_port(0, 1'b1, idx);
                  sb0.push_back(vt[idx].exp_rd);
                  busy[0] = 1'b1;
               end else if (n == 1 && pq1.size() > 0) begin
                  idx = pq1.pop_front();
                  set_port(1, 1'b1, idx);
                  sb1.push_back(vt[idx].exp_rd);
                  busy[1] = 1'b1;
               end
            end
         end
         done = !busy[0] && !busy[1] && pq0.size() == 0 && pq1.size() == 0;
      end
      check1("run_completed", done, 1'b1);
      for (int n = 0; n < 2; n++) begin
         check1($sformatf("p%0d_wait_held", n), wait_bad[n], 1'b0);
         check1($sformatf("p%0d_no_spurious_ready", n), spur[n], 1'b0);
         if (!used[n]) check1($sformatf("p%0d_idle_quiet", n), quiet_bad[n], 1'b0);
      end
      set_port(0, 1'b0, 0);
      set_port(1, 1'b0, 0);
      sb0.delete(); sb1.delete(); pq0.delete(); pq1.delete();
   endtask

   initial begin
      int   order, t_v, t_t, n_to, n_rdy;
      logic wait_at_to, regrant, bad;

      vt[0] = '{mk_insn(7'h01, 3'b000), 32'd7,        32'd6,        32'd42};
      vt[1] = '{mk_insn(7'h01, 3'b011), 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
      vt[2] = '{mk_insn(7'h01, 3'b000), 32'd3,        32'hFFFFFFFB, 32'hFFFFFFF1};
      vt[3] = '{mk_insn(7'h01, 3'b000), 32'h12345678, 32'h10,       32'h23456780};
      vt[4] = '{mk_insn(7'h01, 3'b001), 32'h80000000, 32'h80000000, 32'h40000000};
      vt[5] = '{mk_insn(7'h01, 3'b010), 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF};
      vt[6] = '{mk_insn(7'h01, 3'b000), 32'd2,        32'd3,        32'd6};

      stub = 1'b0;
      set_port(0, 1'b0, 0);
      set_port(1, 1'b0, 0);
      @(negedge clk);
      check1("reset_outputs_rr", any_out[0], 1'b0);
      check1("reset_outputs_fp", any_out[1], 1'b0);
      resetn = 1'b1;

      // Single port 0 MUL 7*6.
      pq0.push_back(0);
      run_ports(0, 60, order);
      check("single_order", order, 1);

      // Tie, then port 0 re-requests while port 1 still waits: expect p0, p1, p0.
      do_reset();
      pq0.push_back(1); pq0.push_back(3); pq1.push_back(2);
      run_ports(0, 120, order);
      check("rr_order", order, 25);

      // Fixed priority: port 0 keeps winning, port 1 last.
      do_reset();
      pq0.push_back(0); pq0.push_back(4); pq0.push_back(5); pq1.push_back(2);
      run_ports(1, 150, order);
      check("fp_order", order, 86);

      // Silent coprocessor: abort, then no regrant while valid stays high.
      do_reset();
      stub = 1'b1;
      set_port(0, 1'b1, 0);
      t_v = -1; t_t = -1; n_to = 0; n_rdy = 0; wait_at_to = 1'bx; regrant = 1'b0;
      for (int c = 0; c < 45; c++) begin
         @(negedge clk);
         if (t_t >= 0 && (m_valid[0] || p0_wait[0])) regrant = 1'b1;
         if (m_valid[0] && t_v < 0) t_v = c;
         if (timeout_err[0]) begin
            n_to++;
            if (t_t < 0) begin
               t_t = c;
               wait_at_to = p0_wait[0];
            end
         end
         if (p0_ready[0]) n_rdy++;
      end
      check("timeout_delay", t_t - t_v, 16);
      check("timeout_pulses", n_to, 1);
      check("abort_no_ready", n_rdy, 0);
      check1("abort_wait_low", wait_at_to, 1'b0);
      check1("blocked_no_regrant", regrant, 1'b0);
      set_port(0, 1'b0, 0);
      stub = 1'b0;
      pq0.push_back(4);
      run_ports(0, 60, order);
      check("unblocked_order", order, 1);

      // ADD on port 1 must be ignored.
      do_reset();
      p1_valid = 1'b1;
      p1_insn = {7'h00, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011};
      p1_rs1 = 32'd1;
      p1_rs2 = 32'd2;
      bad = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (m_valid[0] || p1_wait[0] || p1_ready[0] || p1_wr[0]) bad = 1'b1;
      end
      check1("nonmatch_ignored", bad, 1'b0);
      p1_valid = 1'b0;

      // Asynchronous reset in BUSY, then recovery on port 1.
      do_reset();
      stub = 1'b1;
      set_port(0, 1'b1, 0);
      repeat (4) @(negedge clk);
      check1("busy_before_reset", m_valid[0], 1'b1);
      resetn = 1'b0;
      #1;
      check1("async_reset_clears", any_out[0], 1'b0);
      set_port(0, 1'b0, 0);
      @(negedge clk);
      resetn = 1'b1;
      stub = 1'b0;
      pq1.push_back(6);
      run_ports(0, 60, order);
      check("reset_recovery_order", order, 2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
